// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with a prefetch queue.
// Issues in-order pipelined reads to instruction memory, buffers the returned
// instructions with their PCs in a DEPTH-entry FIFO and presents them to decode.
// Redirects flush the queue and discard responses to requests issued before
// the redirect. Halt only stops new requests; in-flight work still completes.
module fetch_prefetch_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       INSTR_W  = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               halt,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [ADDR_W-1:0]  mem_req_addr,
   input  logic               mem_rsp_valid,
   input  logic [INSTR_W-1:0] mem_rsp_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               idle
);

   localparam int unsigned       PTR_W     = $clog2(DEPTH);
   localparam int unsigned       CNT_W     = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INSTR_W / 8);
   localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(DEPTH);

   // Fetch and response-side PCs
   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  shadow_pc;

   // Prefetch queue storage and bookkeeping
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [ADDR_W-1:0]  pc_mem    [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;

   // Requests accepted but not yet answered, and how many of those are stale
   logic [CNT_W-1:0]   inflight;
   logic [CNT_W-1:0]   drop;
   logic [CNT_W-1:0]   inflight_nxt;

   logic credit_ok;
   logic req_fire;
   logic rsp_live;
   logic push;
   logic pop;

   // Handshake decode, credit check and output muxing
   always_comb begin
      // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
      credit_ok     = ({1'b0, count} + {1'b0, inflight}) < DEPTH_LIM;
      // Held low during reset so the request channel is quiet until rst falls.
      mem_req_valid = !rst && !halt && credit_ok;
      mem_req_addr  = fetch_pc;
      req_fire      = mem_req_valid && mem_req_ready;
      // A response with nothing outstanding is a leftover from before reset.
      rsp_live      = mem_rsp_valid && (inflight != '0);
      push          = rsp_live && (drop == '0) && !redirect_valid;
      out_valid     = (count != '0);
      pop           = out_valid && out_ready;
      out_instr     = out_valid ? instr_mem[rd_ptr] : '0;
      out_pc        = out_valid ? pc_mem[rd_ptr] : '0;
      idle          = (count == '0) && (inflight == '0) && (drop == '0);
   end

   // Outstanding-request count after this cycle's accept and response
   always_comb begin
      inflight_nxt = inflight;
      if (req_fire && !rsp_live) begin
         inflight_nxt = inflight + CNT_W'(1);
      end else if (!req_fire && rsp_live) begin
         inflight_nxt = inflight - CNT_W'(1);
      end
   end

   // Control state: PCs, queue pointers/count, inflight and drop counters
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         fetch_pc  <= RESET_PC;
         shadow_pc <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         inflight  <= '0;
         drop      <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (redirect_valid) begin
            // Everything still outstanding, including a request accepted this
            // cycle, belongs to the old stream and must be discarded.
            fetch_pc  <= redirect_pc;
            shadow_pc <= redirect_pc;
            drop      <= inflight_nxt;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + PC_STEP;
            end
            if (rsp_live && (drop != '0)) begin
               drop <= drop - CNT_W'(1);
            end
            if (push) begin
               wr_ptr    <= wr_ptr + PTR_W'(1);
               shadow_pc <= shadow_pc + PC_STEP;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
               count <= count + CNT_W'(1);
            end else if (pop && !push) begin
               count <= count - CNT_W'(1);
            end
         end
      end
   end

   // Queue storage write port
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; out_instr/out_pc are masked by out_valid, so stale contents are never visible.
      if (push) begin
         instr_mem[wr_ptr] <= mem_rsp_data;
         pc_mem[wr_ptr]    <= shadow_pc;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed testbench for fetch_prefetch_unit (default parameters).
// A behavioural memory returns data = addr ^ 16'hC3A5 after a programmable
// latency; accepted request addresses and decode pops are logged and compared
// against hand-derived sequences.
module tb_fetch_prefetch_unit;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
   } pop_t;

   logic        clk;
   logic        rst;
   logic        halt;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [15:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [15:0] mem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic        idle;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          lat   = 1;
   int          edge_n = 0;
   pend_t       pend[$];
   logic [15:0] acc_log[$];
   pop_t        pop_log[$];

   fetch_prefetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .idle           (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_log.size()) return {16'h0, acc_log[i]};
      return 32'hDEAD_0000;
   endfunction

   function automatic logic [31:0] pop_pc_at(input int i);
      if (i < pop_log.size()) return {16'h0, pop_log[i].pc};
      return 32'hDEAD_0001;
   endfunction

   function automatic logic [31:0] pop_instr_at(input int i);
      if (i < pop_log.size()) return {16'h0, pop_log[i].instr};
      return 32'hDEAD_0002;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pend.delete();
      acc_log.delete();
      pop_log.delete();
      tick(2);
      rst = 1'b0;
   endtask

   // Memory model and logging: sample handshakes at the rising edge,
   // present the next due response at the falling edge.
   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         edge_n++;
         if (mem_rsp_valid && pend.size() > 0) pend.delete(0);
         if (!rst && mem_req_valid && mem_req_ready) begin
            pend.push_back('{addr: mem_req_addr, due: edge_n + lat});
            acc_log.push_back(mem_req_addr);
         end
         if (!rst && out_valid && out_ready)
            pop_log.push_back('{pc: out_pc, instr: out_instr});
         @(negedge clk);
         if (pend.size() > 0 && pend[0].due <= edge_n + 1) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mdata(pend[0].addr);
         end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b1;
      out_ready      = 1'b1;
      lat            = 1;

      // ---- Reset values ----
      tick(2);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_addr", mem_req_addr, 16'h0000);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_idle", idle, 1);

      // ---- Streaming, 1-cycle memory ----
      rst = 1'b0;
      #1;
      check("stream_first_req", mem_req_valid, 1);
      tick();
      check("stream_e1_out_valid", out_valid, 0);
      check("stream_e1_addr", mem_req_addr, 16'h0002);
      check("stream_e1_idle", idle, 0);
      tick();
      for (int i = 0; i < 6; i++) begin
         check("stream_out_valid", out_valid, 1);
         check("stream_out_pc", out_pc, 2 * i);
         check("stream_out_instr", out_instr, mdata(16'(2 * i)));
         tick();
      end

      // ---- Backpressure: queue fills after 4 accepts ----
      out_ready = 1'b0;
      do_reset();
      tick(4);
      check("bp_req_dropped", mem_req_valid, 0);
      check("bp_accepts", acc_log.size(), 4);
      check("bp_addr", mem_req_addr, 16'h0008);
      tick(3);
      check("bp_still_dropped", mem_req_valid, 0);
      check("bp_accepts_hold", acc_log.size(), 4);
      check("bp_out_valid", out_valid, 1);
      check("bp_head_pc", out_pc, 16'h0000);
      check("bp_no_pops", pop_log.size(), 0);
      out_ready = 1'b1;
      tick(8);
      for (int i = 0; i < 5; i++) begin
         check("bp_drain_pc", pop_pc_at(i), 2 * i);
         check("bp_drain_instr", pop_instr_at(i), mdata(16'(2 * i)));
      end

      // ---- Redirect with 3 in flight, incl. same-cycle accept ----
      lat = 3;
      do_reset();
      tick(2);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      tick();
      redirect_valid = 1'b0;
      check("rdA_addr", mem_req_addr, 16'h0100);
      check("rdA_req_valid", mem_req_valid, 1);
      check("rdA_accepts", acc_log.size(), 3);
      check("rdA_stale_accept", acc_at(2), 16'h0004);
      tick(10);
      check("rdA_pop0_pc", pop_pc_at(0), 16'h0100);
      check("rdA_pop0_instr", pop_instr_at(0), mdata(16'h0100));
      check("rdA_pop1_pc", pop_pc_at(1), 16'h0102);
      check("rdA_pop2_pc", pop_pc_at(2), 16'h0104);

      // ---- Redirect with same-cycle response, accept and pop ----
      lat = 2;
      do_reset();
      tick(3);
      check("rdB_pre_valid", out_valid, 1);
      check("rdB_pre_pc", out_pc, 16'h0000);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      tick();
      redirect_valid = 1'b0;
      check("rdB_flushed", out_valid, 0);
      check("rdB_addr", mem_req_addr, 16'h0100);
      check("rdB_accepts", acc_log.size(), 4);
      check("rdB_idle", idle, 0);
      tick(10);
      check("rdB_pop0_pc", pop_pc_at(0), 16'h0000);
      check("rdB_pop1_pc", pop_pc_at(1), 16'h0100);
      check("rdB_pop1_instr", pop_instr_at(1), mdata(16'h0100));
      check("rdB_pop2_pc", pop_pc_at(2), 16'h0102);

      // ---- Halt with 3-cycle memory ----
      lat = 3;
      do_reset();
      tick(3);
      halt = 1'b1;
      #1;
      check("halt_req_valid", mem_req_valid, 0);
      tick();
      check("halt_busy", idle, 0);
      tick(6);
      check("halt_idle", idle, 1);
      check("halt_accepts", acc_log.size(), 3);
      check("halt_out_valid", out_valid, 0);
      check("halt_pops", pop_log.size(), 3);
      check("halt_pop2_pc", pop_pc_at(2), 16'h0004);
      halt = 1'b0;
      #1;
      check("halt_resume_valid", mem_req_valid, 1);
      check("halt_resume_addr", mem_req_addr, 16'h0006);
      tick(8);
      check("halt_resume_pop", pop_pc_at(3), 16'h0006);

      // ---- Redirect during halt, stall and address wrap ----
      lat           = 1;
      halt          = 1'b1;
      mem_req_ready = 1'b0;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      tick();
      redirect_valid = 1'b0;
      check("wrap_halt_addr", mem_req_addr, 16'hFFFE);
      check("wrap_halt_valid", mem_req_valid, 0);
      check("wrap_halt_idle", idle, 1);
      halt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", mem_req_valid, 1);
         check("stall_addr", mem_req_addr, 16'hFFFE);
      end
      mem_req_ready = 1'b1;
      tick();
      check("wrap_next_addr", mem_req_addr, 16'h0000);
      check("wrap_acc0", acc_at(0), 16'hFFFE);
      tick(6);
      check("wrap_acc1", acc_at(1), 16'h0000);
      check("wrap_pop0_pc", pop_pc_at(0), 16'hFFFE);
      check("wrap_pop0_instr", pop_instr_at(0), mdata(16'hFFFE));
      check("wrap_pop1_pc", pop_pc_at(1), 16'h0000);

      // ---- Reset mid-burst with late stale responses ----
      lat = 3;
      do_reset();
      tick(2);
      rst  = 1'b1;
      halt = 1'b1;
      #1;
      check("mrst_req_valid", mem_req_valid, 0);
      check("mrst_req_addr", mem_req_addr, 16'h0000);
      check("mrst_out_valid", out_valid, 0);
      check("mrst_out_pc", out_pc, 0);
      check("mrst_out_instr", out_instr, 0);
      check("mrst_idle", idle, 1);
      acc_log.delete();
      pop_log.delete();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mrst_stale_idle", idle, 1);
         check("mrst_stale_out", out_valid, 0);
      end
      halt = 1'b0;
      tick(6);
      check("mrst_acc0", acc_at(0), 16'h0000);
      check("mrst_pop0_pc", pop_pc_at(0), 16'h0000);
      check("mrst_pop0_instr", pop_instr_at(0), mdata(16'h0000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
